// File: rtl/multimode_counter_pkg.sv
// Shared definitions for the multimode counter: step-mode encodings and
// parameter legality limits.
package multimode_counter_pkg;

   typedef enum logic [1:0] {
      MODE_UP1 = 2'b00,
      MODE_DN1 = 2'b01,
      MODE_UPS = 2'b10,
      MODE_DNS = 2'b11
   } mode_e;

   localparam int unsigned WIDTH_MIN = 32'd2;
   localparam int unsigned WIDTH_MAX = 32'd16;
   localparam int unsigned DIV_MIN   = 32'd1;
   localparam int unsigned DIV_MAX   = 32'd67108864;

   function automatic bit params_legal(input int unsigned width,
                                       input int unsigned div,
                                       input int unsigned step);
      bit ok;
      ok = (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (div >= DIV_MIN) && (div <= DIV_MAX) &&
           (step >= 32'd1) && (step <= ((32'd1 << width) - 32'd1));
      return ok;
   endfunction

endpackage

// File: rtl/multimode_counter_tick_divider.sv
// Prescaler: counts enabled clock cycles 0..DIV-1 and flags the last one as a tick.
module tick_divider #(
   parameter int unsigned DIV = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int unsigned PW = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 32'd1);

   logic [PW-1:0] pcnt_r;
   logic          at_last_s;

   assign at_last_s = (pcnt_r == LAST);
   // Gated by reset so no step is ever requested while the block is held clear.
   assign tick = enable & ~reset & at_last_s;

   // Prescaler count: advances only while enabled, returns to zero on the tick edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pcnt_r <= {PW{1'b0}};
      end else if (enable) begin
         if (at_last_s) begin
            pcnt_r <= {PW{1'b0}};
         end else begin
            pcnt_r <= pcnt_r + PW'(1'b1);
         end
      end else begin
         pcnt_r <= pcnt_r;
      end
   end

endmodule

// File: rtl/multimode_counter.sv
// Up/down counter with selectable step, wrap or saturate overflow handling,
// synchronous load and a prescaler that paces the steps.
module multimode_counter
   import multimode_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DIV   = 1,
   parameter int unsigned STEP  = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             saturate,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             wrap,
   output logic             at_limit
);

   localparam bit PARAMS_OK = params_legal(WIDTH, DIV, STEP);

   generate
      if (!PARAMS_OK) begin : g_param_check
         $error("multimode_counter: illegal WIDTH/DIV/STEP combination");
      end
   endgenerate

   localparam logic [WIDTH:0]   ONE_X    = (WIDTH + 1)'(1'b1);
   localparam logic [WIDTH:0]   STEP_X   = (WIDTH + 1)'(STEP);
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

   mode_e            mode_s;
   logic             down_s;
   logic [WIDTH:0]   delta_s;
   logic [WIDTH:0]   result_s;
   logic             over_s;
   logic [WIDTH-1:0] next_count_s;
   logic             next_wrap_s;
   logic             tick_s;
   logic [WIDTH-1:0] count_r;
   logic             wrap_r;

   tick_divider #(
      .DIV (DIV)
   ) u_tick_divider (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .tick   (tick_s)
   );

   // Step direction and size decoded from the current mode.
   always_comb begin
      mode_s  = mode_e'(mode);
      down_s  = 1'b0;
      delta_s = ONE_X;
      case (mode_s)
         MODE_UP1: begin
            down_s  = 1'b0;
            delta_s = ONE_X;
         end
         MODE_DN1: begin
            down_s  = 1'b1;
            delta_s = ONE_X;
         end
         MODE_UPS: begin
            down_s  = 1'b0;
            delta_s = STEP_X;
         end
         MODE_DNS: begin
            down_s  = 1'b1;
            delta_s = STEP_X;
         end
         default: begin
            down_s  = 1'b0;
            delta_s = ONE_X;
         end
      endcase
   end

   // One extra bit catches both carry-out going up and borrow going down.
   always_comb begin
      result_s     = {WIDTH + 1{1'b0}};
      over_s       = 1'b0;
      next_count_s = ZERO;
      next_wrap_s  = 1'b0;
      if (down_s) begin
         result_s = {1'b0, count_r} - delta_s;
      end else begin
         result_s = {1'b0, count_r} + delta_s;
      end
      over_s = result_s[WIDTH];
      if (saturate) begin
         next_wrap_s = 1'b0;
         if (over_s) begin
            next_count_s = down_s ? ZERO : ALL_ONES;
         end else begin
            next_count_s = result_s[WIDTH-1:0];
         end
      end else begin
         next_count_s = result_s[WIDTH-1:0];
         next_wrap_s  = over_s;
      end
   end

   // Count and wrap registers: load beats a tick step, otherwise hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r <= ZERO;
         wrap_r  <= 1'b0;
      end else if (load) begin
         count_r <= load_value;
         wrap_r  <= 1'b0;
      end else if (tick_s) begin
         count_r <= next_count_s;
         wrap_r  <= next_wrap_s;
      end else begin
         count_r <= count_r;
         wrap_r  <= 1'b0;
      end
   end

   assign count    = count_r;
   assign wrap     = wrap_r;
   assign tick     = tick_s;
   assign at_limit = down_s ? (count_r == ZERO) : (count_r == ALL_ONES);

endmodule

// File: tb/tb_multimode_counter.sv
// Directed and randomized checks of two counter instances (DIV=1 and DIV=4)
// against an integer reference model.
module tb_multimode_counter;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic [1:0] mode;
   logic       saturate;
   logic       load;
   logic [3:0] load_value;

   logic [3:0] count_o    [2];
   logic       tick_o     [2];
   logic       wrap_o     [2];
   logic       at_limit_o [2];

   int n_tests = 0;
   int n_fail  = 0;

   int divs  [2] = '{1, 4};
   int m_cnt [2];
   int m_pc  [2];
   int m_wr  [2];

   always #5 clock = ~clock;

   multimode_counter #(.WIDTH(4), .DIV(1), .STEP(3)) u_div1 (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode),
      .saturate(saturate), .load(load), .load_value(load_value),
      .count(count_o[0]), .tick(tick_o[0]), .wrap(wrap_o[0]),
      .at_limit(at_limit_o[0])
   );

   multimode_counter #(.WIDTH(4), .DIV(4), .STEP(3)) u_div4 (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode),
      .saturate(saturate), .load(load), .load_value(load_value),
      .count(count_o[1]), .tick(tick_o[1]), .wrap(wrap_o[1]),
      .at_limit(at_limit_o[1])
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0;
         m_pc[i]  = 0;
         m_wr[i]  = 0;
      end
   endtask

   task automatic check_all(input string where);
      for (int i = 0; i < 2; i++) begin
         int t_exp;
         int al_exp;
         t_exp  = (enable && !reset && (m_pc[i] == divs[i] - 1)) ? 1 : 0;
         al_exp = mode[0] ? ((m_cnt[i] == 0) ? 1 : 0) : ((m_cnt[i] == 15) ? 1 : 0);
         chk($sformatf("%s div%0d count", where, divs[i]), 16'(count_o[i]), 16'(m_cnt[i]));
         chk($sformatf("%s div%0d wrap", where, divs[i]), 16'(wrap_o[i]), 16'(m_wr[i]));
         chk($sformatf("%s div%0d tick", where, divs[i]), 16'(tick_o[i]), 16'(t_exp));
         chk($sformatf("%s div%0d at_limit", where, divs[i]), 16'(at_limit_o[i]), 16'(al_exp));
      end
   endtask

   // Behavioural next state for one rising edge, from the current inputs.
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         bit t;
         int d;
         int r;
         if (reset) begin
            m_cnt[i] = 0;
            m_pc[i]  = 0;
            m_wr[i]  = 0;
         end else begin
            t = enable && (m_pc[i] == divs[i] - 1);
            if (enable) m_pc[i] = t ? 0 : m_pc[i] + 1;
            if (load) begin
               m_cnt[i] = int'(load_value);
               m_wr[i]  = 0;
            end else if (t) begin
               d = mode[1] ? 3 : 1;
               r = mode[0] ? m_cnt[i] - d : m_cnt[i] + d;
               if (saturate) begin
                  m_wr[i]  = 0;
                  m_cnt[i] = (r > 15) ? 15 : ((r < 0) ? 0 : r);
               end else begin
                  m_wr[i]  = (r > 15 || r < 0) ? 1 : 0;
                  m_cnt[i] = (r + 16) % 16;
               end
            end else begin
               m_wr[i] = 0;
            end
         end
      end
   endtask

   task automatic step(input string where);
      @(negedge clock);
      check_all(where);
      model_edge();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      mode       = 2'b00;
      saturate   = 1'b0;
      load       = 1'b0;
      load_value = 4'd0;
      model_reset();

      @(posedge clock);
      #1;
      check_all("reset_up");
      mode = 2'b01;
      #1;
      check_all("reset_dn");
      mode = 2'b00;
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Count up through the 15 -> 0 wrap.
      enable = 1'b1;
      repeat (17) step("up1");
      chk("up1 div1 final", 16'(count_o[0]), 16'd1);

      // Large-step down with wrap from 0.
      load = 1'b1;
      load_value = 4'd0;
      step("load0");
      load = 1'b0;
      mode = 2'b11;
      repeat (7) step("dns_wrap");

      // Saturating large-step up from 12.
      mode = 2'b10;
      saturate = 1'b1;
      load = 1'b1;
      load_value = 4'd12;
      step("load12");
      load = 1'b0;
      repeat (5) step("ups_sat");
      chk("ups_sat div1 held", 16'(count_o[0]), 16'd15);

      // Prescaler with enable dropped mid-period.
      mode = 2'b00;
      saturate = 1'b0;
      repeat (6) step("pre_run");
      enable = 1'b0;
      repeat (3) step("pre_hold");
      enable = 1'b1;
      repeat (10) step("pre_resume");

      // Load colliding with a tick.
      load = 1'b1;
      load_value = 4'd9;
      step("collide");
      load = 1'b0;
      chk("collide div1 count", 16'(count_o[0]), 16'd9);
      repeat (3) step("after_collide");

      // Randomized mix of all controls.
      for (int k = 0; k < 300; k++) begin
         mode       = 2'($urandom_range(0, 3));
         saturate   = 1'($urandom_range(0, 1));
         enable     = ($urandom_range(0, 3) != 0);
         load       = ($urandom_range(0, 11) == 0);
         load_value = 4'($urandom_range(0, 15));
         step("rand");
      end

      // Reset asserted between edges at count 7.
      mode = 2'b00;
      saturate = 1'b0;
      enable = 1'b1;
      load = 1'b1;
      load_value = 4'd7;
      step("load7");
      load = 1'b0;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all("async_rst");
      chk("async_rst div1 count", 16'(count_o[0]), 16'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (10) step("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
